arcade_input_ctrl: RTL and testbench

Input-conditioning stage that sits directly upstream of the ladybug game core. It decodes hps_io PS/2 key events and merges them with both joysticks. A start press runs an auto-coin sequence: coin pulse, gap, then start pulse. The block drives the core's active-low 2-bit button vectors from registers.

---
 rtl/arcade_input_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_arcade_input_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl
//   Input conditioning for the ladybug core. It decodes hps_io PS/2 key events,
//   ORs them with both joysticks, and runs an auto-coin sequence on a start
//   press: a coin pulse, then a gap, then a start pulse for the latched player.
//   All button outputs are registered and active-low.
//
// Ports
//   clk_sys      system clock, rising edge
//   reset        synchronous, active-high
//   ps2_key      hps_io key event ([64] toggles once per event)
//   joystick_0/1 active-high joystick bits, OR-ed together
//   but_*_s      active-low 2-bit button vectors, [1] held at 1
//   but_select_s active-low {start2, start1}, driven only by the auto-coin FSM
//   busy         auto-coin sequence in progress
module arcade_input_ctrl #(
   parameter int unsigned COIN_LEN  = 200000,
   parameter int unsigned GAP_LEN   = 400000,
   parameter int unsigned START_LEN = 200000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [64:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   output logic [1:0]  but_coin_s,
   output logic [1:0]  but_fire_s,
   output logic [1:0]  but_bomb_s,
   output logic [1:0]  but_tilt_s,
   output logic [1:0]  but_select_s,
   output logic [1:0]  but_up_s,
   output logic [1:0]  but_down_s,
   output logic [1:0]  but_left_s,
   output logic [1:0]  but_right_s,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StCoin, StGap, StStart} state_e;

   // ---------------------------------------------------------------------------
   // PS/2 event decode
   // ---------------------------------------------------------------------------
   logic       pressed;
   logic       extended;
   logic [8:0] code;
   logic       toggle_q;
   logic       key_event;

   assign pressed   = (ps2_key[15:8] != 8'hF0);
   assign extended  = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
   // PRNSCR/PAUSE carry extra bytes; they map to no key.
   assign code      = (ps2_key[63:24] != 40'd0) ? 9'd0 : {extended, ps2_key[7:0]};
   assign key_event = ps2_key[64] ^ toggle_q;

   logic key_up_q, key_down_q, key_left_q, key_right_q;
   logic key_fire_q, key_bomb_q, key_start1_q, key_start2_q, key_coin_q;

   always_ff @(posedge clk_sys) begin
      toggle_q <= ps2_key[64];
      if (reset) begin
         key_up_q     <= 1'b0;
         key_down_q   <= 1'b0;
         key_left_q   <= 1'b0;
         key_right_q  <= 1'b0;
         key_fire_q   <= 1'b0;
         key_bomb_q   <= 1'b0;
         key_start1_q <= 1'b0;
         key_start2_q <= 1'b0;
         key_coin_q   <= 1'b0;
      end else if (key_event) begin
         case (code)
            9'h075, 9'h175: key_up_q     <= pressed;
            9'h072, 9'h172: key_down_q   <= pressed;
            9'h06B, 9'h16B: key_left_q   <= pressed;
            9'h074, 9'h174: key_right_q  <= pressed;
            9'h014:         key_fire_q   <= pressed;
            9'h029:         key_bomb_q   <= pressed;
            9'h005:         key_start1_q <= pressed;
            9'h006:         key_start2_q <= pressed;
            9'h004:         key_coin_q   <= pressed;
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Joystick merge
   // ---------------------------------------------------------------------------
   // Joysticks are registered so they line up with the key registers: both are
   // visible on the outputs one edge after being captured. Sampling continues
   // through reset so a start held across reset is already seen as "high" and
   // cannot produce a spurious edge afterwards.
   logic [8:0] joy_q;
   logic       unused_joy;

   assign unused_joy = ^{joystick_0[15:9], joystick_1[15:9]};

   always_ff @(posedge clk_sys) begin
      joy_q <= joystick_0[8:0] | joystick_1[8:0];
   end

   logic m_right, m_left, m_down, m_up, m_fire, m_bomb, m_start1, m_start2, m_coin;

   assign m_right  = key_right_q  | joy_q[0];
   assign m_left   = key_left_q   | joy_q[1];
   assign m_down   = key_down_q   | joy_q[2];
   assign m_up     = key_up_q     | joy_q[3];
   assign m_fire   = key_fire_q   | joy_q[4];
   assign m_bomb   = key_bomb_q   | joy_q[5];
   assign m_start1 = key_start1_q | joy_q[6];
   assign m_start2 = key_start2_q | joy_q[7];
   assign m_coin   = key_coin_q   | joy_q[8];

   // ---------------------------------------------------------------------------
   // Start edge detect
   // ---------------------------------------------------------------------------
   logic prev1_q, prev2_q;
   logic s1_edge, s2_edge;

   assign s1_edge = m_start1 & ~prev1_q;
   assign s2_edge = m_start2 & ~prev2_q;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         prev1_q <= 1'b1;
         prev2_q <= 1'b1;
      end else begin
         prev1_q <= m_start1;
         prev2_q <= m_start2;
      end
   end

   // ---------------------------------------------------------------------------
   // Auto-coin FSM
   // ---------------------------------------------------------------------------
   state_e      state_q, state_d;
   logic [23:0] cnt_q, cnt_d;
   logic        player_q, player_d;  // 0: start1, 1: start2

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      player_d = player_q;
      unique case (state_q)
         StIdle: begin
            if (s1_edge || s2_edge) begin
               player_d = ~s1_edge;  // start1 wins a tie
               cnt_d    = 24'(COIN_LEN - 1);
               state_d  = StCoin;
            end
         end
         StCoin: begin
            if (cnt_q == 24'd0) begin
               cnt_d   = 24'(GAP_LEN - 1);
               state_d = StGap;
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
         end
         StGap: begin
            if (cnt_q == 24'd0) begin
               cnt_d   = 24'(START_LEN - 1);
               state_d = StStart;
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
         end
         StStart: begin
            if (cnt_q == 24'd0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= 24'd0;
         player_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         player_q <= player_d;
      end
   end

   assign busy = (state_q != StIdle);

   // ---------------------------------------------------------------------------
   // Output registers
   // ---------------------------------------------------------------------------
   // Coin/select are built from the next state so they switch on the same edge
   // as busy and the state register.
   logic [1:0] coin_q, fire_q, bomb_q, select_q, up_q, down_q, left_q, right_q;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         coin_q   <= 2'b11;
         fire_q   <= 2'b11;
         bomb_q   <= 2'b11;
         select_q <= 2'b11;
         up_q     <= 2'b11;
         down_q   <= 2'b11;
         left_q   <= 2'b11;
         right_q  <= 2'b11;
      end else begin
         coin_q   <= {1'b1, ~((state_d == StCoin) | m_coin)};
         fire_q   <= {1'b1, ~m_fire};
         bomb_q   <= {1'b1, ~m_bomb};
         up_q     <= {1'b1, ~m_up};
         down_q   <= {1'b1, ~m_down};
         left_q   <= {1'b1, ~m_left};
         right_q  <= {1'b1, ~m_right};
         if (state_d == StStart) begin
            select_q <= player_d ? 2'b01 : 2'b10;
         end else begin
            select_q <= 2'b11;
         end
      end
   end

   assign but_coin_s   = coin_q;
   assign but_fire_s   = fire_q;
   assign but_bomb_s   = bomb_q;
   assign but_tilt_s   = 2'b11;
   assign but_select_s = select_q;
   assign but_up_s     = up_q;
   assign but_down_s   = down_q;
   assign but_left_s   = left_q;
   assign but_right_s  = right_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
module tb_arcade_input_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [64:0] ps2_key;
   logic [15:0] joystick_0;
   logic [15:0] joystick_1;
   logic [1:0]  but_coin_s, but_fire_s, but_bomb_s, but_tilt_s, but_select_s;
   logic [1:0]  but_up_s, but_down_s, but_left_s, but_right_s;
   logic        busy;

   int errors = 0;
   int checks = 0;

   arcade_input_ctrl #(
      .COIN_LEN  (3),
      .GAP_LEN   (2),
      .START_LEN (4)
   ) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ps2_key      (ps2_key),
      .joystick_0   (joystick_0),
      .joystick_1   (joystick_1),
      .but_coin_s   (but_coin_s),
      .but_fire_s   (but_fire_s),
      .but_bomb_s   (but_bomb_s),
      .but_tilt_s   (but_tilt_s),
      .but_select_s (but_select_s),
      .but_up_s     (but_up_s),
      .but_down_s   (but_down_s),
      .but_left_s   (but_left_s),
      .but_right_s  (but_right_s),
      .busy         (busy)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic send_key(input logic [39:0] hi, input logic [7:0] b2, input logic [7:0] b1,
                           input logic [7:0] b0);
      ps2_key = {~ps2_key[64], hi, b2, b1, b0};
   endtask

   // One cycle of an auto-coin sequence; k counts edges since the start stimulus.
   task automatic seq_step(input int k, input logic [1:0] sel, input int coin_k);
      logic [1:0] exp_coin;
      logic [1:0] exp_sel;
      tick();
      exp_coin = ((k >= 2 && k <= 4) || k == coin_k) ? 2'b10 : 2'b11;
      exp_sel  = (k >= 7 && k <= 10) ? sel : 2'b11;
      check($sformatf("coin k=%0d", k), {6'd0, but_coin_s}, {6'd0, exp_coin});
      check($sformatf("select k=%0d", k), {6'd0, but_select_s}, {6'd0, exp_sel});
      check($sformatf("busy k=%0d", k), {7'd0, busy}, {7'd0, (k >= 2 && k <= 10)});
   endtask

   initial begin
      reset      = 1'b1;
      ps2_key    = '0;
      joystick_0 = '0;
      joystick_1 = '0;
      tick();
      tick();
      check("rst coin", {6'd0, but_coin_s}, 8'h03);
      check("rst fire", {6'd0, but_fire_s}, 8'h03);
      check("rst bomb", {6'd0, but_bomb_s}, 8'h03);
      check("rst tilt", {6'd0, but_tilt_s}, 8'h03);
      check("rst select", {6'd0, but_select_s}, 8'h03);
      check("rst up", {6'd0, but_up_s}, 8'h03);
      check("rst down", {6'd0, but_down_s}, 8'h03);
      check("rst left", {6'd0, but_left_s}, 8'h03);
      check("rst right", {6'd0, but_right_s}, 8'h03);
      check("rst busy", {7'd0, busy}, 8'h00);
      reset = 1'b0;
      tick();

      // Key up press: output moves two edges after the toggle.
      send_key(40'd0, 8'h00, 8'h00, 8'h75);
      tick();
      check("up after 1 edge", {6'd0, but_up_s}, 8'h03);
      tick();
      check("up pressed", {6'd0, but_up_s}, 8'h02);
      send_key(40'd0, 8'h00, 8'hF0, 8'h75);
      tick();
      tick();
      check("up released", {6'd0, but_up_s}, 8'h03);

      // Extended right.
      send_key(40'd0, 8'h00, 8'hE0, 8'h74);
      tick();
      tick();
      check("ext right pressed", {6'd0, but_right_s}, 8'h02);

      // Long-code event must be ignored.
      send_key(40'h12, 8'h00, 8'h00, 8'h75);
      tick();
      tick();
      check("prnscr up", {6'd0, but_up_s}, 8'h03);
      check("prnscr right", {6'd0, but_right_s}, 8'h02);

      // Extended release (E0 in [23:16]).
      send_key(40'd0, 8'hE0, 8'hF0, 8'h74);
      tick();
      tick();
      check("ext right released", {6'd0, but_right_s}, 8'h03);

      // Joystick fire latency and bomb via key.
      joystick_0 = 16'h0010;
      send_key(40'd0, 8'h00, 8'h00, 8'h29);
      tick();
      check("fire after 1 edge", {6'd0, but_fire_s}, 8'h03);
      tick();
      check("fire joy", {6'd0, but_fire_s}, 8'h02);
      check("bomb key", {6'd0, but_bomb_s}, 8'h02);
      check("no seq from dirs", {7'd0, busy}, 8'h00);
      joystick_0 = 16'h0000;
      send_key(40'd0, 8'h00, 8'hF0, 8'h29);
      tick();
      tick();
      check("fire off", {6'd0, but_fire_s}, 8'h03);
      check("bomb off", {6'd0, but_bomb_s}, 8'h03);

      // Sequence 1: start2 pulse on joystick_1.
      joystick_1 = 16'h0080;
      for (int k = 1; k <= 13; k++) begin
         seq_step(k, 2'b01, 0);
         if (k == 1) joystick_1 = 16'h0000;
      end

      // Sequence 2: simultaneous starts, extra start1 during GAP is dropped.
      joystick_0 = 16'h00C0;
      for (int k = 1; k <= 13; k++) begin
         seq_step(k, 2'b10, 0);
         if (k == 1) joystick_0 = 16'h0000;
         if (k == 5) joystick_0 = 16'h0040;
         if (k == 6) joystick_0 = 16'h0000;
      end

      // Sequence 3: key start1, released mid-sequence, manual coin during GAP.
      send_key(40'd0, 8'h00, 8'h00, 8'h05);
      for (int k = 1; k <= 13; k++) begin
         seq_step(k, 2'b10, 7);
         if (k == 3) send_key(40'd0, 8'h00, 8'hF0, 8'h05);
         if (k == 5) joystick_0 = 16'h0100;
         if (k == 6) joystick_0 = 16'h0000;
      end

      // Reset during START with start1 held.
      joystick_0 = 16'h0040;
      for (int k = 1; k <= 8; k++) tick();
      check("pre-reset busy", {7'd0, busy}, 8'h01);
      check("pre-reset select", {6'd0, but_select_s}, 8'h02);
      reset = 1'b1;
      tick();
      check("mid rst select", {6'd0, but_select_s}, 8'h03);
      check("mid rst coin", {6'd0, but_coin_s}, 8'h03);
      check("mid rst busy", {7'd0, busy}, 8'h00);
      reset = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check($sformatf("held start idle %0d", k), {7'd0, busy}, 8'h00);
      end
      joystick_0 = 16'h0000;
      tick();
      tick();
      joystick_0 = 16'h0040;
      tick();
      check("repress busy k1", {7'd0, busy}, 8'h00);
      tick();
      check("repress busy k2", {7'd0, busy}, 8'h01);
      joystick_0 = 16'h0000;
      for (int k = 3; k <= 12; k++) tick();
      check("final idle", {7'd0, busy}, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
